// File: rtl/axil_cmd_pkg.sv
// Shared types for axil_cmd_master: FSM state encoding and AXI response codes.
// The DRAIN state only exists when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
package axil_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    RSP
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    , DRAIN
`endif
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding command-to-AXI4-Lite master bridge.
// Optional watchdog/drain logic is enabled with `define AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  input  logic                  cmd_we,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  // Only elaborates for an unsupported parameter set, leaving a marker scope in the hierarchy.
  if (STRB_WIDTH != DATA_WIDTH / 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             we_q, we_d;
  logic             done_now;

  assign rsp_timeout   = to_q;
  assign m_axil_bready = (state_q == WRESP) || (state_q == DRAIN && we_q);
  assign m_axil_rready = (state_q == RDATA) || (state_q == DRAIN && !we_q);
`else
  assign rsp_timeout   = 1'b0;
  assign m_axil_bready = (state_q == WRESP);
  assign m_axil_rready = (state_q == RDATA);
`endif

  assign cmd_ready      = (state_q == IDLE) && !rst;
  assign rsp_valid      = (state_q == RSP);
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_arvalid = arvalid_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    // Valids fall only on their own handshake, whatever state the FSM is in.
    awvalid_d = awvalid_q && !m_axil_awready;
    wvalid_d  = wvalid_q && !m_axil_wready;
    arvalid_d = arvalid_q && !m_axil_arready;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = to_q;
    we_d     = we_q;
    done_now = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          cnt_d = '0;
          we_d  = cmd_we;
`endif
        end
      end
      WRITE: begin
        if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) state_d = WRESP;
      end
      WRESP: begin
        if (m_axil_bvalid) begin
          resp_d  = m_axil_bresp;
          rdata_d = '0;
          state_d = RSP;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          done_now = 1'b1;
`endif
        end
      end
      RADDR: begin
        if (m_axil_arready) state_d = RDATA;
      end
      RDATA: begin
        if (m_axil_rvalid) begin
          rdata_d = m_axil_rdata;
          resp_d  = m_axil_rresp;
          state_d = RSP;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          done_now = 1'b1;
`endif
        end
      end
      RSP: begin
        if (rsp_ready) begin
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          state_d = to_q ? DRAIN : IDLE;
          to_d    = 1'b0;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      // The abandoned transaction still owes the slave its B or R handshake.
      DRAIN: begin
        if (we_q ? m_axil_bvalid : m_axil_rvalid) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    if (state_q inside {WRITE, WRESP, RADDR, RDATA}) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !done_now) begin
        state_d = RSP;
        resp_d  = SLVERR;
        rdata_d = '0;
        to_d    = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      cnt_q <= '0;
      to_q  <= 1'b0;
      we_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      cnt_q <= cnt_d;
      to_q  <= to_d;
      we_q  <= we_d;
`endif
    end
  end

  // Command payload is only meaningful while a valid qualifies it, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small behavioural AXI4-Lite RAM slave.
// Timeout scenario runs when AXIL_CMD_MASTER_TIMEOUT_EN is defined; otherwise the indefinite-wait case runs.
`timescale 1ns/1ps
module tb_axil_cmd_master;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          cmd_we, cmd_valid, cmd_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout, rsp_valid, rsp_ready;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DW-1:0] m_axil_wdata, m_axil_rdata;
  logic [SW-1:0] m_axil_wstrb;
  logic [1:0]    m_axil_bresp, m_axil_rresp;
  logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic          m_axil_rvalid, m_axil_rready;

  always #5 clk = ~clk;

  axil_cmd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_we(cmd_we),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  // Behavioural slave: ready asserted after a programmable number of stalled cycles.
  int            aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic          ar_block = 1'b0, b_block = 1'b0;
  logic [1:0]    slv_bresp = 2'b00;
  int            aw_cnt, w_cnt, ar_cnt;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_addr_s;
  logic [DW-1:0] w_data_s;
  logic [SW-1:0] w_strb_s;
  logic [DW-1:0] mem [0:63];
  logic          aw_have, w_have, commit;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;

  assign m_axil_awready = m_axil_awvalid && !aw_got && (aw_cnt >= aw_wait);
  assign m_axil_wready  = m_axil_wvalid && !w_got && (w_cnt >= w_wait);
  assign m_axil_arready = m_axil_arvalid && !m_axil_rvalid && !ar_block && (ar_cnt >= ar_wait);
  assign aw_have = aw_got || (m_axil_awvalid && m_axil_awready);
  assign w_have  = w_got || (m_axil_wvalid && m_axil_wready);
  assign commit  = aw_have && w_have && !m_axil_bvalid && !b_block;
  assign wr_addr = aw_got ? aw_addr_s : m_axil_awaddr;
  assign wr_data = w_got ? w_data_s : m_axil_wdata;
  assign wr_strb = w_got ? w_strb_s : m_axil_wstrb;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      m_axil_bvalid <= 1'b0; m_axil_bresp <= 2'b00;
      m_axil_rvalid <= 1'b0; m_axil_rresp <= 2'b00; m_axil_rdata <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= (m_axil_awvalid && !m_axil_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axil_wvalid && !m_axil_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_axil_arvalid && !m_axil_arready) ? ar_cnt + 1 : 0;
      if (m_axil_awvalid && m_axil_awready) begin aw_got <= 1'b1; aw_addr_s <= m_axil_awaddr; end
      if (m_axil_wvalid && m_axil_wready) begin
        w_got <= 1'b1; w_data_s <= m_axil_wdata; w_strb_s <= m_axil_wstrb;
      end
      if (commit) begin
        for (int i = 0; i < SW; i++)
          if (wr_strb[i]) mem[wr_addr[7:2]][8*i +: 8] <= wr_data[8*i +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        m_axil_bvalid <= 1'b1; m_axil_bresp <= slv_bresp;
      end else if (m_axil_bvalid && m_axil_bready) begin
        m_axil_bvalid <= 1'b0;
      end
      if (m_axil_arvalid && m_axil_arready) begin
        m_axil_rvalid <= 1'b1; m_axil_rdata <= mem[m_axil_araddr[7:2]]; m_axil_rresp <= 2'b00;
      end else if (m_axil_rvalid && m_axil_rready) begin
        m_axil_rvalid <= 1'b0;
      end
    end
  end

  // Protocol monitor: a stalled valid must stay high with a stable payload; count responses.
  int            n_viol = 0, n_rsp_hs = 0, cyc = 0, hs_cyc = 0;
  logic          aw_stall_p, w_stall_p, ar_stall_p;
  logic [AW-1:0] awaddr_p, araddr_p;
  logic [DW-1:0] wdata_p;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      aw_stall_p <= 1'b0; w_stall_p <= 1'b0; ar_stall_p <= 1'b0;
    end else begin
      n_viol <= n_viol
        + ((aw_stall_p && (!m_axil_awvalid || m_axil_awaddr != awaddr_p)) ? 1 : 0)
        + ((w_stall_p && (!m_axil_wvalid || m_axil_wdata != wdata_p)) ? 1 : 0)
        + ((ar_stall_p && (!m_axil_arvalid || m_axil_araddr != araddr_p)) ? 1 : 0);
      aw_stall_p <= m_axil_awvalid && !m_axil_awready; awaddr_p <= m_axil_awaddr;
      w_stall_p  <= m_axil_wvalid && !m_axil_wready;   wdata_p  <= m_axil_wdata;
      ar_stall_p <= m_axil_arvalid && !m_axil_arready; araddr_p <= m_axil_araddr;
      if (rsp_valid && rsp_ready) n_rsp_hs <= n_rsp_hs + 1;
    end
  end

  int n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    int n = 0;
    cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_bound", cmd_ready, 1);
    @(posedge clk); #1;
    hs_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  // lat = index of the first rsp_valid cycle, counting the cmd handshake cycle as 0.
  task automatic wait_rsp(output int lat, output logic [DW-1:0] rd, output logic [1:0] rs,
                          output logic to);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    if (!rsp_valid) chk("rsp_valid_bound", rsp_valid, 1);
    lat = cyc - hs_cyc + 1;
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat, n0, bad, n;
    logic [DW-1:0] rd;
    logic [1:0]    rs;
    logic          to;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready,
                     rsp_valid, rsp_timeout, cmd_ready}, 8'h00);
    chk("rst_rsp", {rsp_resp, rsp_rdata}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    // Write then read back, zero-wait slave
    send_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    wait_rsp(lat, rd, rs, to);
    chk("wr_lat", lat, 3);
    chk("wr_resp", rs, 2'b00);
    chk("wr_rdata", rd, 0);
    chk("wr_timeout", to, 0);
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(lat, rd, rs, to);
    chk("rd_lat", lat, 3);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_resp", rs, 2'b00);

    // W accepted 4 cycles before AW, partial strobes
    aw_wait = 4; n0 = n_rsp_hs;
    send_cmd(1'b1, 16'h0020, 32'h12345678, 4'b0011);
    @(negedge clk);
    chk("ww_c1_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
    @(negedge clk);
    chk("ww_c2_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b10);
    wait_rsp(lat, rd, rs, to);
    chk("ww_lat", lat, 7);
    chk("ww_resp", rs, 2'b00);
    repeat (3) @(negedge clk);
    chk("ww_one_rsp", n_rsp_hs - n0, 1);
    aw_wait = 0;
    send_cmd(1'b0, 16'h0020, 32'h0, 4'h0);
    wait_rsp(lat, rd, rs, to);
    chk("ww_readback", rd, 32'h00005678);

    // Response back-pressure
    rsp_ready = 1'b0;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(lat, rd, rs, to);
    chk("bp_lat", lat, 3);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== 32'hDEADBEEF || cmd_ready) bad++;
    end
    chk("bp_hold_bad_cycles", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release", {rsp_valid, cmd_ready}, 2'b01);

    // Slave error response
    slv_bresp = 2'b10;
    send_cmd(1'b1, 16'h0030, 32'h0BADF00D, 4'hF);
    wait_rsp(lat, rd, rs, to);
    chk("slverr_resp", rs, 2'b10);
    chk("slverr_timeout", to, 0);
    slv_bresp = 2'b00;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // Watchdog on a withheld arready, then drain after a late arready
    ar_block = 1'b1; n0 = n_rsp_hs;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(lat, rd, rs, to);
    chk("to_lat", lat, 17);
    chk("to_flag_resp", {to, rs}, 3'b110);
    chk("to_rdata", rd, 0);
    @(negedge clk);
    chk("to_drain", {m_axil_arvalid, m_axil_rready, cmd_ready}, 3'b110);
    repeat (3) @(negedge clk);
    chk("to_arvalid_held", m_axil_arvalid, 1);
    ar_block = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("to_back_idle", cmd_ready, 1);
    chk("to_one_rsp", n_rsp_hs - n0, 1);
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(lat, rd, rs, to);
    chk("to_next_read", {to, rs, rd}, {3'b000, 32'hDEADBEEF});
`else
    // No watchdog: a withheld arready is waited on indefinitely
    ar_block = 1'b1;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || !m_axil_arvalid || rsp_timeout) bad++;
    end
    chk("nto_wait_bad_cycles", bad, 0);
    ar_block = 1'b0;
    wait_rsp(lat, rd, rs, to);
    chk("nto_lat", lat, 42);
    chk("nto_rdata", rd, 32'hDEADBEEF);
`endif

    // Reset while waiting for B
    b_block = 1'b1; n0 = n_rsp_hs;
    send_cmd(1'b1, 16'h0040, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("rr_in_wresp", {m_axil_bready, m_axil_awvalid, m_axil_wvalid}, 3'b100);
    #1 rst = 1'b1;
    #1;
    chk("rr_rst_outputs", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
                           m_axil_rready, rsp_valid, cmd_ready}, 7'h00);
    b_block = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_ready_after", cmd_ready, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("rr_no_rsp_cycles", bad, 0);
    chk("rr_no_rsp_hs", n_rsp_hs - n0, 0);

    chk("protocol_violations", n_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width in bits (8, 16, 32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI-Lite address width in bits.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit; used only when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STRB_WIDTH  write strobes.
- cmd_we  in  1  1=write, 0=read.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  response produced by watchdog.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- m_axil_aw*/w*/b*/ar*/r*  full AXI4-Lite master set (awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready); widths per parameters; awprot = arprot = 3'b000.

Function
REQ-006 SHALL execute one command at a time; cmd_ready = 1 only in IDLE.
REQ-007 SHALL use FSM states IDLE, WRITE, WRESP, RADDR, RDATA, RSP, DRAIN.
REQ-008 On cmd handshake with cmd_we=1, SHALL register addr/data/strb and assert awvalid and wvalid together in the next cycle (state WRITE).
REQ-009 In WRITE, SHALL track AW and W handshakes independently, drop each valid after its own handshake, and go to WRESP once both are done, in any order including the same cycle.
REQ-010 In WRESP, SHALL hold bready=1; on the B handshake, SHALL capture bresp, set rsp_rdata=0, and go to RSP.
REQ-011 On cmd handshake with cmd_we=0, SHALL assert arvalid in the next cycle (RADDR); after the AR handshake go to RDATA with rready=1; on the R handshake capture rdata/rresp and go to RSP.
REQ-012 In RSP, SHALL hold rsp_valid=1 with stable outputs until rsp_ready; then return to IDLE. Minimum latency, cmd handshake to rsp_valid: 3 cycles (write and read), with a zero-wait-state slave.
REQ-013 SHALL never deassert any AXI valid before its handshake, and SHALL keep the address/data stable while valid.
REQ-014 SHALL keep bready and rready at 0 outside WRESP, RDATA and DRAIN.

Reset
REQ-015 On rst, SHALL asynchronously force IDLE, all AXI valids/readies 0, cmd_ready 0 while rst is asserted, rsp_valid 0, rsp_timeout 0, and rsp_resp/rsp_rdata 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction with no response; cmd_ready=1 the first cycle after rst deasserts.

Configuration
REQ-017 With AXIL_CMD_MASTER_TIMEOUT_EN defined:
- A counter SHALL clear on leaving IDLE and count each cycle in WRITE/WRESP/RADDR/RDATA.
- When the count reaches TIMEOUT_CYCLES, the block SHALL enter RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
- After rsp_ready, it SHALL go to DRAIN, finish any outstanding AXI handshakes (valids held, ready high), discard the result, then return to IDLE.
REQ-018 Without the macro, SHALL have no counter and no DRAIN state; rsp_timeout SHALL be tied to 0, and the block SHALL wait indefinitely.

Structure
REQ-019 A shared package axil_cmd_pkg SHALL hold the FSM state enum and the response codes OKAY=2'b00 and SLVERR=2'b10.
REQ-020 SHALL be a single module with no sub-modules.

Verification
REQ-021 Write 0x0010 data 0xDEADBEEF strb 4'hF against an axil_ram slave -> rsp_resp=00 three cycles after the cmd handshake; a subsequent read of 0x0010 returns 0xDEADBEEF.
REQ-022 Slave accepts W 4 cycles before AW -> wvalid drops after its handshake, awvalid is held, and exactly one response is produced.
REQ-023 Read with rsp_ready held low 10 cycles -> rsp_valid and rsp_rdata stable; cmd_ready=0 throughout.
REQ-024 Slave returns bresp=2'b10 -> rsp_resp=2'b10, rsp_timeout=0.
REQ-025 TIMEOUT_EN, TIMEOUT_CYCLES=16, slave withholds arready -> rsp_timeout=1 and rsp_resp=2'b10 after 16 cycles; arvalid stays high until a late arready, then IDLE.
REQ-026 rst asserted while in WRESP -> all valids 0 immediately, and no rsp_valid appears afterward.
